sub_div_ctrl: RTL and testbench

Sequential unsigned divider controller built around the existing parameterized subtractor `sub_mod`. The divider is restoring and produces one quotient bit per clock.
- It sequences a single `sub_mod` instance (width size+1) through size iterations.
- Each iteration uses `c_out` (no-borrow) to decide the quotient bit and whether to restore the partial remainder.
- It is the first multi-cycle ALU operation and is started and polled by the ALU top-level.

---
 rtl/sub_div_ctrl_pkg.sv | 10 +
 rtl/sub_div_ctrl_if.sv | 23 ++
 rtl/sub_div_ctrl_sub.sv | 16 +
 rtl/sub_div_ctrl.sv | 108 ++++++++++
 tb/tb_sub_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sub_div_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding.
package sub_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/sub_div_ctrl_if.sv
// Start/operand/result bundle between the ALU top-level (master) and the divider (slave).
interface sub_div_ctrl_if #(
    parameter int size = 4
);
    logic            start;
    logic [size-1:0] dividend;
    logic [size-1:0] divisor;
    logic            busy;
    logic            done;
    logic [size-1:0] quotient;
    logic [size-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sub_div_ctrl_sub.sv
// Purely combinational subtractor: diff = a - b, c_out = 1 when no borrow (a >= b).
module sub_mod #(
    parameter int size = 5
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size-1:0] diff,
    output logic            c_out
);
    logic [size:0] full;

    // Two's-complement subtract; the carry out of a + ~b + 1 is the no-borrow flag.
    assign full  = {1'b0, a} + {1'b0, ~b} + {{size{1'b0}}, 1'b1};
    assign diff  = full[size-1:0];
    assign c_out = full[size];
endmodule

// File: rtl/sub_div_ctrl.sv
// Restoring divider controller: one quotient bit per clock using a shared size+1 bit subtractor.
module sub_div_ctrl
    import sub_div_ctrl_pkg::*;
#(
    parameter int size = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_div_ctrl_if.slave bus
);
    localparam int              CW           = $clog2(size + 1);
    localparam logic [size-1:0] DBZ_QUOTIENT = '1;

    state_e          state, state_next;
    logic [size-1:0] q_reg, d_reg;
    logic [size-1:0] r_reg;
    logic [CW-1:0]   count;
    logic [size:0]   t_val, diff;
    logic [size-1:0] r_next, q_next;
    logic            c_out;
    logic            accept, last_iter, busy, done;
    logic [size-1:0] quotient, remainder;
    logic            div_by_zero;
    logic            unused_diff_msb;

    assign accept    = (state == ST_IDLE) && bus.start;
    assign last_iter = (state == ST_CALC) && (count == CW'(1));

    // Shifted partial remainder; only the compare needs the extra bit, the result always fits size bits.
    assign t_val           = {r_reg, q_reg[size-1]};
    assign r_next          = c_out ? diff[size-1:0] : t_val[size-1:0];
    assign q_next          = {q_reg[size-2:0], c_out};
    assign unused_diff_msb = diff[size];

    sub_mod #(size + 1) u_sub (
        .a    (t_val),
        .b    ({1'b0, d_reg}),
        .diff (diff),
        .c_out(c_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE: if (bus.start) state_next = (bus.divisor == '0) ? ST_FIN : ST_CALC;
            ST_CALC: if (count == CW'(1)) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_CALC: busy = 1'b1;
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: every datapath register is reset; there is no memory array here, so nothing is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (bus.divisor == '0) begin
                quotient    <= DBZ_QUOTIENT;
                remainder   <= bus.dividend;
                div_by_zero <= 1'b1;
            end else begin
                q_reg       <= bus.dividend;
                d_reg       <= bus.divisor;
                r_reg       <= '0;
                count       <= CW'(size);
                div_by_zero <= 1'b0;
            end
        end else if (state == ST_CALC) begin
            r_reg <= r_next;
            q_reg <= q_next;
            count <= count - 1'b1;
            // Publish the final bit in the same edge so results are valid on entry to FIN.
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_sub_div_ctrl.sv
// Self-checking bench for sub_div_ctrl: directed, randomized and exhaustive operands vs plain / and %.
module tb_sub_div_ctrl;
    localparam int SIZE = 4;
    localparam int MASK = (1 << SIZE) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    sub_div_ctrl_if #(.size(SIZE)) bus ();

    sub_div_ctrl #(.size(SIZE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model straight from the arithmetic definition.
    function automatic void model(input int a, input int b, output logic [SIZE-1:0] q,
                                  output logic [SIZE-1:0] r, output logic z);
        if (b == 0) begin
            q = SIZE'(MASK); r = SIZE'(a); z = 1'b1;
        end else begin
            q = SIZE'(a / b); r = SIZE'(a % b); z = 1'b0;
        end
    endfunction

    // Edges from the accepting edge (inclusive) to the edge that raises done.
    function automatic int exp_latency(input int b);
        return (b == 0) ? 1 : SIZE + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL idle_wait: busy=%0b done=%0b after %0d cycles, required idle", bus.busy, bus.done, n);
        end
    endtask

    // Issues one start pulse, scrambles operands after acceptance, waits for done (bounded).
    task automatic run_op(input int a, input int b, output int edges, output logic [SIZE-1:0] q,
                          output logic [SIZE-1:0] r, output logic z, output logic busy_at_done);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = SIZE'(a);
        bus.divisor  = SIZE'(b);
        edges = 0;
        do begin
            tick();
            edges++;
            bus.start    = 1'b0;
            bus.dividend = SIZE'($urandom);
            bus.divisor  = SIZE'($urandom);
        end while (!bus.done && edges < 40);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        int ta[7] = '{10, 15, 15, 7, 0, 13, 12};
        int tb[7] = '{3, 8, 1, 9, 5, 0, 4};
        int edges;
        logic [SIZE-1:0] q, r, qe, re;
        logic z, ze, bsy;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], edges, q, r, z, bsy);
            model(ta[i], tb[i], qe, re, ze);
            checks++;
            if (edges != exp_latency(tb[i])) begin
                errors++;
                $display("FAIL dir_latency %0d/%0d: got %0d edges, required %0d", ta[i], tb[i], edges, exp_latency(tb[i]));
            end
            checks++;
            if (q !== qe || r !== re || z !== ze) begin
                errors++;
                $display("FAIL dir_result %0d/%0d: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         ta[i], tb[i], q, r, z, qe, re, ze);
            end
            checks++;
            if (bsy !== 1'b0) begin
                errors++;
                $display("FAIL dir_busy_in_fin %0d/%0d: busy=%0b, required 0", ta[i], tb[i], bsy);
            end
            tick();
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL dir_done_pulse %0d/%0d: done=%0b one cycle later, required 0", ta[i], tb[i], bus.done);
            end
        end
    endtask

    task automatic test_ignore_start();
        int edges;
        wait_idle();
        bus.start = 1'b1; bus.dividend = SIZE'(10); bus.divisor = SIZE'(3);
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy: busy=%0b in second calc cycle, required 1", bus.busy);
        end
        bus.start = 1'b1; bus.dividend = SIZE'(14); bus.divisor = SIZE'(2);
        tick();
        bus.start = 1'b0;
        edges = 3;
        while (!bus.done && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != SIZE + 1 || bus.quotient !== SIZE'(3) || bus.remainder !== SIZE'(1) || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ign_result: edges=%0d q=%0d r=%0d dbz=%0b, required edges=%0d q=3 r=1 dbz=0",
                     edges, bus.quotient, bus.remainder, bus.div_by_zero, SIZE + 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL ign_no_queue: cycle %0d busy=%0b done=%0b, required both 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        wait_idle();
        bus.start = 1'b1; bus.dividend = SIZE'(10); bus.divisor = SIZE'(3);
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            errors++;
            $display("FAIL abort_async: busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with busy/done after abort, required 0", done_seen);
        end
    endtask

    task automatic test_random();
        int a, b, edges;
        logic [SIZE-1:0] q, r, qe, re;
        logic z, ze, bsy;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, MASK);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
            run_op(a, b, edges, q, r, z, bsy);
            model(a, b, qe, re, ze);
            checks++;
            if (q !== qe || r !== re || z !== ze || edges != exp_latency(b)) begin
                errors++;
                $display("FAIL rand %0d/%0d: q=%0d r=%0d dbz=%0b edges=%0d, required q=%0d r=%0d dbz=%0b edges=%0d",
                         a, b, q, r, z, edges, qe, re, ze, exp_latency(b));
            end
        end
    endtask

    // All operand pairs with start held high; done spacing is IDLE + FIN + calc cycles.
    task automatic test_sweep();
        int edge_cnt = 0, prev_edge = 0, n, a, b, exp_gap;
        logic [SIZE-1:0] qe, re;
        logic ze;
        wait_idle();
        bus.start = 1'b1; bus.dividend = '0; bus.divisor = '0;
        for (int i = 0; i < 256; i++) begin
            a = i >> SIZE;
            b = i & MASK;
            n = 0;
            do begin
                tick();
                edge_cnt++;
                n++;
            end while (!bus.done && n < 20);
            model(a, b, qe, re, ze);
            checks++;
            if (bus.quotient !== qe || bus.remainder !== re || bus.div_by_zero !== ze) begin
                errors++;
                $display("FAIL sweep %0d/%0d: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                         a, b, bus.quotient, bus.remainder, bus.div_by_zero, qe, re, ze);
            end
            if (i > 0) begin
                exp_gap = 2 + ((b == 0) ? 0 : SIZE);
                checks++;
                if (edge_cnt - prev_edge != exp_gap) begin
                    errors++;
                    $display("FAIL sweep_spacing %0d/%0d: done gap %0d cycles, required %0d",
                             a, b, edge_cnt - prev_edge, exp_gap);
                end
            end
            prev_edge = edge_cnt;
            if (i < 255) begin
                bus.dividend = SIZE'((i + 1) >> SIZE);
                bus.divisor  = SIZE'((i + 1) & MASK);
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
